// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU: op codes (also used by the
// ALU control decoder), FSM state encoding and the op legality decode.
package seq_alu_pkg;

    localparam logic [3:0] OP_AND     = 4'b0000;
    localparam logic [3:0] OP_OR      = 4'b0001;
    localparam logic [3:0] OP_NOR     = 4'b0010;
    localparam logic [3:0] OP_ADD     = 4'b0011;
    localparam logic [3:0] OP_SUB     = 4'b0100;
    localparam logic [3:0] OP_SLL     = 4'b0101;
    localparam logic [3:0] OP_SRL     = 4'b0110;
    localparam logic [3:0] OP_ILLEGAL = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Shifts are legal only with the shamt flag set; everything else only without it.
    function automatic logic op_is_illegal(input logic [3:0] op, input logic shamt_flag);
        case (op)
            OP_AND, OP_OR, OP_NOR, OP_ADD, OP_SUB: return shamt_flag;
            OP_SLL, OP_SRL:                        return !shamt_flag;
            default:                               return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/seq_alu_shift_unit.sv
// Shift engine for seq_alu. Default build: work register + down counter,
// one bit per cycle. With SEQ_ALU_BARREL_SHIFT_EN defined: a single-cycle
// barrel shifter that is always ready.
// 'result' is combinational: on the load cycle it is the final value when
// amount is zero; afterwards it is work shifted once more, final when ready.
module seq_alu_shift_unit #(
    parameter int NBITS = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             dir,
    input  logic [SHW-1:0]   amount,
    input  logic [NBITS-1:0] data,
    output logic             ready,
    output logic [NBITS-1:0] result
);

`ifdef SEQ_ALU_BARREL_SHIFT_EN

    // dir=1 is a logical right shift, dir=0 a left shift; zero fill both ways.
    assign result = dir ? (data >> amount) : (data << amount);
    assign ready  = 1'b1;

    logic unused_ok;
    assign unused_ok = &{1'b0, clk, reset, load};

`else

    logic [NBITS-1:0] work;
    logic [SHW-1:0]   cnt;
    logic             dir_q;
    logic [NBITS-1:0] stepped;

    assign stepped = dir_q ? (work >> 1) : (work << 1);
    assign result  = load ? data : stepped;
    assign ready   = load ? (amount == '0) : (cnt == SHW'(1));

    // Load operand and count on acceptance, then shift one bit per cycle until the count runs out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            work  <= '0;
            cnt   <= '0;
            dir_q <= 1'b0;
        end else if (load) begin
            work  <= data;
            cnt   <= amount;
            dir_q <= dir;
        end else if (cnt != '0) begin
            work  <= stepped;
            cnt   <= cnt - SHW'(1);
        end
    end

`endif

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU behind the ALU control decoder, start/busy/done handshake.
// Handshake: start is sampled only in IDLE; an accepted request raises busy
// while a shift iterates; done pulses for one cycle with ALUResult, Zero and
// Illegal updated on that same cycle; start while not IDLE is dropped.
// Optional macro SEQ_ALU_BARREL_SHIFT_EN: single-cycle barrel shifts.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int NBITS = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       ALUOperation,
    input  logic             ALUShamt,
    input  logic [NBITS-1:0] A,
    input  logic [NBITS-1:0] B,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic             done,
    output logic [NBITS-1:0] ALUResult,
    output logic             Zero,
    output logic             Illegal,
    output logic [1:0]       dbg_state
);

    state_t           state;
    logic             op_shift;
    logic             op_illegal;
    logic             shift_load;
    logic             shift_ready;
    logic [NBITS-1:0] shift_result;
    logic [NBITS-1:0] quick_result;

    assign op_shift   = ALUShamt && ((ALUOperation == OP_SLL) || (ALUOperation == OP_SRL));
    assign op_illegal = op_is_illegal(ALUOperation, ALUShamt);
    assign shift_load = (state == ST_IDLE) && start && op_shift;
    assign dbg_state  = state;

    seq_alu_shift_unit #(.NBITS(NBITS), .SHW(SHW)) u_shift (
        .clk    (clk),
        .reset  (reset),
        .load   (shift_load),
        .dir    (ALUOperation == OP_SRL),
        .amount (shamt),
        .data   (B),
        .ready  (shift_ready),
        .result (shift_result)
    );

    // Single-cycle logic/adder path; illegal ops produce zero.
    always_comb begin
        quick_result = '0;
        if (!op_illegal) begin
            case (ALUOperation)
                OP_AND:  quick_result = A & B;
                OP_OR:   quick_result = A | B;
                OP_NOR:  quick_result = ~(A | B);
                OP_ADD:  quick_result = A + B;
                OP_SUB:  quick_result = A - B;
                default: quick_result = '0;
            endcase
        end
    end

    // Control FSM with registered handshake outputs and result registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            ALUResult <= '0;
            Zero      <= 1'b1;
            Illegal   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (op_shift && !shift_ready) begin
                            state <= ST_SHIFT;
                            busy  <= 1'b1;
                        end else begin
                            state     <= ST_DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            ALUResult <= op_shift ? shift_result : quick_result;
                            Zero      <= (op_shift ? shift_result : quick_result) == '0;
                            Illegal   <= op_illegal;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (shift_ready) begin
                        state     <= ST_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        ALUResult <= shift_result;
                        Zero      <= shift_result == '0;
                        Illegal   <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed scoreboard bench for seq_alu (default and SEQ_ALU_BARREL_SHIFT_EN builds).
module tb_seq_alu;

    localparam int NBITS = 32;
    localparam int SHW   = 5;

`ifdef SEQ_ALU_BARREL_SHIFT_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [3:0]       op = 4'b0000;
    logic             shf = 1'b0;
    logic [NBITS-1:0] a = '0;
    logic [NBITS-1:0] b = '0;
    logic [SHW-1:0]   sh = '0;
    logic             busy;
    logic             done;
    logic [NBITS-1:0] res;
    logic             zero;
    logic             ill;
    logic [1:0]       dbg_state;

    typedef struct {
        logic [NBITS-1:0] res;
        logic             zero;
        logic             ill;
        int               cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    seq_alu #(.NBITS(NBITS), .SHW(SHW)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .ALUOperation (op),
        .ALUShamt     (shf),
        .A            (a),
        .B            (b),
        .shamt        (sh),
        .busy         (busy),
        .done         (done),
        .ALUResult    (res),
        .Zero         (zero),
        .Illegal      (ill),
        .dbg_state    (dbg_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // monitor: pop and compare whenever done is presented
    always @(negedge clk) begin
        if (reset && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result", res, e.res);
                check("zero", zero, e.zero);
                check("illegal", ill, e.ill);
                check("latency_cycle", cyc, e.cyc);
                check("busy_at_done", busy, 0);
            end
        end
    end

    // driver: one-cycle start pulse; lat counts clocks from acceptance edge to done
    task automatic issue(input logic [3:0] o, input logic f, input logic [NBITS-1:0] va,
                         input logic [NBITS-1:0] vb, input logic [SHW-1:0] vs,
                         input logic [NBITS-1:0] er, input logic ei, input int lat, input bit push);
        exp_t e;
        @(negedge clk);
        op = o; shf = f; a = va; b = vb; sh = vs; start = 1'b1;
        if (push) begin
            e.res = er; e.zero = (er == '0); e.ill = ei; e.cyc = cyc + lat;
            exp_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #2;
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("done_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    function automatic int shift_lat(input int amt);
        return BARREL ? 1 : amt + 1;
    endfunction

    initial begin
        // reset values
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", res, 0);
        check("rst_zero", zero, 1);
        check("rst_illegal", ill, 0);
        check("rst_state", dbg_state, 0);
        @(negedge clk);
        reset = 1'b1;

        // add wraps to zero, sub goes negative
        issue(4'b0011, 0, 32'hFFFF_FFFF, 32'h1, 0, 32'h0, 0, 1, 1);
        drain();
        issue(4'b0100, 0, 32'd5, 32'd7, 0, 32'hFFFF_FFFE, 0, 1, 1);
        drain();
        issue(4'b0001, 0, 32'h0F, 32'hF0, 0, 32'hFF, 0, 1, 1);
        drain();

        // shifts
        issue(4'b0101, 1, 32'hDEAD, 32'h3, 5'd4, 32'h30, 0, shift_lat(4), 1);
`ifndef SEQ_ALU_BARREL_SHIFT_EN
        check("busy_in_shift", busy, 1);
        check("state_shift", dbg_state, 1);
`endif
        drain();
        issue(4'b0110, 1, 32'h0, 32'h8000_0000, 5'd31, 32'h1, 0, shift_lat(31), 1);
        drain();
        issue(4'b0101, 1, 32'h0, 32'h1234, 5'd0, 32'h1234, 0, 1, 1);
        drain();

        // start and operand changes while busy are ignored
        issue(4'b0110, 1, 32'h0, 32'hABCD_0000, 5'd8, 32'h00AB_CD00, 0, shift_lat(8), 1);
        @(negedge clk);
        op = 4'b0011; shf = 1'b0; b = 32'h0; sh = 5'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (3) @(negedge clk);

        // illegal decodes, then a legal NOR
        issue(4'b1001, 0, 32'h5, 32'h6, 0, 32'h0, 1, 1, 1);
        drain();
        issue(4'b0000, 1, 32'hFF, 32'hFF, 5'd3, 32'h0, 1, 1, 1);
        drain();
        issue(4'b0101, 0, 32'h1, 32'h1, 5'd2, 32'h0, 1, 1, 1);
        drain();
        issue(4'b0010, 0, 32'h0, 32'h0, 0, 32'hFFFF_FFFF, 0, 1, 1);
        drain();

        // reset mid-shift
        issue(4'b0101, 1, 32'h0, 32'h1, 5'd20, 32'h0, 0, 0, 0);
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_result", res, 0);
        check("midrst_zero", zero, 1);
        check("midrst_state", dbg_state, 0);
        @(negedge clk);
        reset = 1'b1;
        issue(4'b0101, 1, 32'h0, 32'h1, 5'd2, 32'h4, 0, shift_lat(2), 1);
        drain();

        // back-to-back with start held high; A scrambled between acceptances
        @(negedge clk);
        op = 4'b0000; shf = 1'b0; b = 32'hFF00;
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            a = 32'hF0F0;
            start = 1'b1;
            e.res = 32'hF000; e.zero = 1'b0; e.ill = 1'b0; e.cyc = cyc + 1;
            exp_q.push_back(e);
            @(negedge clk);
            a = $urandom_range(0, 32'hFFFF);
            if (i == 3) start = 1'b0;
            @(negedge clk);
        end
        drain();

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1);
    end

endmodule
